// File: rtl/alu_pkg.sv
// Shared constants and types for the ALU sharing arbiter.
package alu_pkg;

    localparam int DEFAULT_WIDTH = 6;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;

    // Bit positions inside the {SF,CF,ZF} flag vector
    localparam int SF = 2;
    localparam int CF = 1;
    localparam int ZF = 0;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ISSUE   = 3'd1,
        ST_WAIT    = 3'd2,
        ST_CAPTURE = 3'd3,
        ST_RESP    = 3'd4
    } arb_state_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-input round-robin picker; only consulted while the arbiter is idle.
module rr_arbiter2 (
    input  logic [1:0] valid,
    input  logic       last_grant,
    output logic       grant_id
);

    // Lone requester wins; on a tie the one not served last wins.
    always_comb begin
        grant_id = 1'b0;
        case (valid)
            2'b10:   grant_id = 1'b1;
            2'b11:   grant_id = ~last_grant;
            default: grant_id = 1'b0;
        endcase
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one ALU between two requesters, one operation at a time.
//
//  state      | meaning
//  -----------+----------------------------------------------------
//  ST_IDLE    | waiting for a request, ALU inputs held at zero
//  ST_ISSUE   | latched operands driven onto the ALU
//  ST_WAIT    | ALU pipeline latency, down-counter to zero
//  ST_CAPTURE | result and flags registered
//  ST_RESP    | response offered to the stored requester only
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int WIDTH   = DEFAULT_WIDTH,
    parameter int ALU_LAT = 0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             req0_valid,
    input  logic             req1_valid,
    output logic             req0_ready,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [1:0]       req0_op,
    input  logic [1:0]       req1_op,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [1:0]       alu_op,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_sf,
    input  logic             alu_cf,
    input  logic             alu_zf,
    output logic             rsp0_valid,
    output logic             rsp1_valid,
    input  logic             rsp0_ready,
    input  logic             rsp1_ready,
    output logic [WIDTH-1:0] rsp_result,
    output logic [2:0]       rsp_flags,
    output logic             busy
);

    localparam int CNT_W = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;

    arb_state_t       state;
    logic             last_grant;
    logic             owner;
    logic             grant_id;
    logic [CNT_W-1:0] wait_cnt;
    logic             idle;
    logic             any_req;
    logic             rsp_done;

    rr_arbiter2 u_rr (
        .valid      ({req1_valid, req0_valid}),
        .last_grant (last_grant),
        .grant_id   (grant_id)
    );

    assign idle       = (state == ST_IDLE);
    assign any_req    = req0_valid | req1_valid;
    assign req0_ready = idle & any_req & ~grant_id;
    assign req1_ready = idle & any_req &  grant_id;
    assign busy       = ~idle;
    // The non-owner's ready never matters: its valid is held low.
    assign rsp_done   = (state == ST_RESP) &
                        (owner ? (rsp1_valid & rsp1_ready) : (rsp0_valid & rsp0_ready));

    // Sequencing FSM; ALU inputs and response outputs are registered here.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            last_grant <= 1'b1;
            owner      <= 1'b0;
            wait_cnt   <= '0;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_op     <= '0;
            rsp0_valid <= 1'b0;
            rsp1_valid <= 1'b0;
            rsp_result <= '0;
            rsp_flags  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (any_req) begin
                        state      <= ST_ISSUE;
                        owner      <= grant_id;
                        last_grant <= grant_id;
                        alu_a      <= grant_id ? req1_a  : req0_a;
                        alu_b      <= grant_id ? req1_b  : req0_b;
                        alu_op     <= grant_id ? req1_op : req0_op;
                    end
                end
                ST_ISSUE: begin
                    if (ALU_LAT > 0) begin
                        state    <= ST_WAIT;
                        wait_cnt <= CNT_W'(ALU_LAT - 1);
                    end else begin
                        state <= ST_CAPTURE;
                    end
                end
                ST_WAIT: begin
                    if (wait_cnt == '0) begin
                        state <= ST_CAPTURE;
                    end else begin
                        wait_cnt <= wait_cnt - 1'b1;
                    end
                end
                ST_CAPTURE: begin
                    rsp_result    <= alu_result;
                    rsp_flags[SF] <= alu_sf;
                    rsp_flags[CF] <= alu_cf;
                    rsp_flags[ZF] <= alu_zf;
                    alu_a         <= '0;
                    alu_b         <= '0;
                    alu_op        <= '0;
                    rsp0_valid    <= ~owner;
                    rsp1_valid    <= owner;
                    state         <= ST_RESP;
                end
                ST_RESP: begin
                    if (rsp_done) begin
                        rsp0_valid <= 1'b0;
                        rsp1_valid <= 1'b0;
                        state      <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
